distortion_sched: RTL and testbench
===================================

DISTORTION_SCHED -- requirements
Module: distortion_sched

Interface
REQ-001 Parameter: DW, 16, audio sample width (signed).
REQ-002 Parameter: LUT_AW, 10, distortion LUT address width.
REQ-003 Parameter: ACK_TIMEOUT, 15, max cycles waited for engine acknowledge.
REQ-004 clk  input  1  clock; all logic rising-edge.
REQ-005 reset_n  input  1  reset; asynchronous, active-low.
REQ-006 sample_strobe  input  1  one-cycle frame-start pulse.
REQ-007 in_l, in_r  input  DW each  signed stereo input samples, valid with sample_strobe.
REQ-008 bypass  input  1  route inputs straight to outputs, engine unused.
REQ-009 cfg_valid, cfg_ready  input / output  1 each  LUT-write handshake.
REQ-010 cfg_addr, cfg_data  input  LUT_AW / 16  LUT-write address/data.
REQ-011 clr_status  input  1  clears sticky status flags.
REQ-012 eng_req  output  1  one-cycle request to shared distortion engine.
REQ-013 eng_sample  output  DW  sample presented with eng_req.
REQ-014 eng_ack, eng_result  input  1 / DW  engine result valid strobe and value.
REQ-015 lut_we, lut_addr, lut_wdata  output  1 / LUT_AW / 16  LUT write port to engine.
REQ-016 out_l, out_r  output  DW each  processed samples, held between frames.
REQ-017 out_valid  output  1  one-cycle pulse: new out_l/out_r present.
REQ-018 err_overrun, err_timeout  output  1 each  sticky status flags.

Function
REQ-019 FSM states SHALL be IDLE, REQ_L, WAIT_L, REQ_R, WAIT_R, DONE.
REQ-020 IDLE + sample_strobe (cycle T): latch in_l/in_r; bypass=0 -> REQ_L at T+1; bypass=1 -> DONE at T+1 with latched inputs as results.
REQ-021 REQ_L/REQ_R: eng_req=1 exactly one cycle, eng_sample=latched left/right; next state WAIT_L/WAIT_R.
REQ-022 eng_ack SHALL be sampled only in WAIT_L/WAIT_R; ack elsewhere ignored.
REQ-023 WAIT_x + eng_ack: capture eng_result as channel result; WAIT_L -> REQ_R, WAIT_R -> DONE.
REQ-024 WAIT counter starts at 0 on entry; ACK_TIMEOUT cycles without ack -> result 0, err_timeout set, advance as if acked.
REQ-025 DONE: out_l/out_r load both results, out_valid=1 that cycle, next IDLE; minimum engine-path latency strobe T -> out_valid T+5, bypass T+1.
REQ-026 sample_strobe in any state other than IDLE SHALL be ignored and set err_overrun.
REQ-027 cfg accepted when cfg_valid & cfg_ready; held in one-entry buffer; cfg_ready = buffer empty.
REQ-028 Buffered write issued (lut_we=1 one cycle) only in IDLE with no sample_strobe that cycle; buffer empties same edge; cfg_ready high next cycle.
REQ-029 Strobe and pending write in same IDLE cycle: strobe wins; write waits until FSM returns to IDLE.
REQ-030 lut_we SHALL never be high while FSM outside IDLE.
REQ-031 clr_status clears both sticky flags; simultaneous set event wins over clear.
REQ-032 eng_sample, lut_addr, lut_wdata hold last value when not strobed.

Reset
REQ-033 reset_n low: FSM IDLE, out_l/out_r=0, out_valid=0, eng_req=0, eng_sample=0, lut_we=0, lut_addr=0, lut_wdata=0, cfg buffer empty (cfg_ready=1 after release), flags 0, timeout counter 0.
REQ-034 Reset mid-frame SHALL abort the frame with no out_valid and drop any buffered cfg write.

Structure
REQ-035 Package distortion_pkg SHALL hold FSM state enum, DW, LUT_AW defaults.
REQ-036 One-entry cfg buffer SHALL be sub-module distortion_cfg_buf (valid/ready in, pop from FSM).

Verification
REQ-037 in_l=0x0100, in_r=-0x0100, eng acks 1 cycle after req with 0x1000/0x2000 -> out_valid at T+5, out_l=0x1000, out_r=0x2000.
REQ-038 bypass=1, in_l=0x1234, in_r=0x00FF -> out_valid T+1, outputs equal inputs, eng_req never high.
REQ-039 No ack on left channel -> after 15 WAIT cycles out_l=0, err_timeout=1; right acked 0x0042 -> out_r=0x0042; clr_status clears flag.
REQ-040 Second strobe at T+2 of active frame -> ignored, err_overrun=1, frame results unchanged.
REQ-041 cfg write addr=0x3FF data=0xBEEF with strobe same cycle -> frame runs first, lut_we pulses in first IDLE after DONE with addr 0x3FF, data 0xBEEF; cfg_ready low until then.
REQ-042 reset_n low during WAIT_R -> all outputs reset per REQ-033, no out_valid; next strobe processes normally.

Source files
------------

// File: rtl/distortion_pkg.sv
// Shared types and default widths for the stereo distortion scheduler.
package distortion_pkg;

    localparam int unsigned DW_DEF          = 16;
    localparam int unsigned LUT_AW_DEF      = 10;
    localparam int unsigned CFG_DW          = 16;
    localparam int unsigned ACK_TIMEOUT_DEF = 15;

    typedef enum logic [2:0] {
        IDLE,
        REQ_L,
        WAIT_L,
        REQ_R,
        WAIT_R,
        DONE
    } state_e;

endpackage

// File: rtl/distortion_cfg_buf.sv
// One-entry holding buffer for LUT writes; ready only while empty, drained by the scheduler's pop.
module distortion_cfg_buf
    import distortion_pkg::*;
#(
    parameter int unsigned AW = LUT_AW_DEF,
    parameter int unsigned DW = CFG_DW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [AW-1:0] cfg_addr,
    input  logic [DW-1:0] cfg_data,
    input  logic          pop,
    output logic          full,
    output logic [AW-1:0] buf_addr,
    output logic [DW-1:0] buf_data
);

    logic          full_q, full_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;

    always_comb begin
        full_d = full_q;
        addr_d = addr_q;
        data_d = data_q;
        if (pop) begin
            full_d = 1'b0;
        end else if (cfg_valid && !full_q) begin
            full_d = 1'b1;
            addr_d = cfg_addr;
            data_d = cfg_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign cfg_ready = !full_q;
    assign full      = full_q;
    assign buf_addr  = addr_q;
    assign buf_data  = data_q;

endmodule

// File: rtl/distortion_sched.sv
// Frame scheduler: sends left then right sample to a shared distortion engine,
// handles ack timeouts, bypass, overrun detection and deferred LUT writes.
module distortion_sched
    import distortion_pkg::*;
#(
    parameter int unsigned DW          = DW_DEF,
    parameter int unsigned LUT_AW      = LUT_AW_DEF,
    parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sample_strobe,
    input  logic [DW-1:0]     in_l,
    input  logic [DW-1:0]     in_r,
    input  logic              bypass,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [LUT_AW-1:0] cfg_addr,
    input  logic [15:0]       cfg_data,
    input  logic              clr_status,
    output logic              eng_req,
    output logic [DW-1:0]     eng_sample,
    input  logic              eng_ack,
    input  logic [DW-1:0]     eng_result,
    output logic              lut_we,
    output logic [LUT_AW-1:0] lut_addr,
    output logic [15:0]       lut_wdata,
    output logic [DW-1:0]     out_l,
    output logic [DW-1:0]     out_r,
    output logic              out_valid,
    output logic              err_overrun,
    output logic              err_timeout
);

    localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DW-1:0]       lat_r_q, lat_r_d;
    logic [DW-1:0]       res_l_q, res_l_d;
    logic [DW-1:0]       out_l_q, out_l_d;
    logic [DW-1:0]       out_r_q, out_r_d;
    logic [DW-1:0]       eng_sample_q, eng_sample_d;
    logic                eng_req_q, eng_req_d;
    logic                out_valid_q, out_valid_d;
    logic                err_overrun_q, err_overrun_d;
    logic                err_timeout_q, err_timeout_d;
    logic [LUT_AW-1:0]   lut_addr_q, lut_addr_d;
    logic [15:0]         lut_wdata_q, lut_wdata_d;

    logic                in_wait, timeout, advance, pop, buf_full;
    logic [DW-1:0]       chan_res;
    logic [LUT_AW-1:0]   buf_addr;
    logic [15:0]         buf_data;

    distortion_cfg_buf #(
        .AW (LUT_AW),
        .DW (16)
    ) u_cfg_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .pop       (pop),
        .full      (buf_full),
        .buf_addr  (buf_addr),
        .buf_data  (buf_data)
    );

    // A strobe in IDLE takes priority over draining the LUT write buffer.
    assign pop = (state_q == IDLE) && !sample_strobe && buf_full;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lat_r_d      = lat_r_q;
        res_l_d      = res_l_q;
        out_l_d      = out_l_q;
        out_r_d      = out_r_q;
        eng_sample_d = eng_sample_q;
        eng_req_d    = 1'b0;
        out_valid_d  = 1'b0;
        lut_addr_d   = lut_addr_q;
        lut_wdata_d  = lut_wdata_q;

        in_wait  = (state_q == WAIT_L) || (state_q == WAIT_R);
        timeout  = in_wait && !eng_ack && (cnt_q == CW'(ACK_TIMEOUT - 1));
        advance  = in_wait && (eng_ack || timeout);
        chan_res = eng_ack ? eng_result : '0;
        if (in_wait && !advance) begin
            cnt_d = cnt_q + CW'(1);
        end

        case (state_q)
            IDLE: begin
                if (sample_strobe) begin
                    lat_r_d = in_r;
                    if (bypass) begin
                        state_d     = DONE;
                        out_l_d     = in_l;
                        out_r_d     = in_r;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d      = REQ_L;
                        eng_req_d    = 1'b1;
                        eng_sample_d = in_l;
                    end
                end
            end
            REQ_L: begin
                state_d = WAIT_L;
                cnt_d   = '0;
            end
            WAIT_L: begin
                if (advance) begin
                    res_l_d      = chan_res;
                    state_d      = REQ_R;
                    eng_req_d    = 1'b1;
                    eng_sample_d = lat_r_q;
                end
            end
            REQ_R: begin
                state_d = WAIT_R;
                cnt_d   = '0;
            end
            WAIT_R: begin
                if (advance) begin
                    out_l_d     = res_l_q;
                    out_r_d     = chan_res;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (pop) begin
            lut_addr_d  = buf_addr;
            lut_wdata_d = buf_data;
        end

        // Set events take precedence over a same-cycle clear.
        err_overrun_d = (sample_strobe && (state_q != IDLE)) || (err_overrun_q && !clr_status);
        err_timeout_d = timeout || (err_timeout_q && !clr_status);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            lat_r_q       <= '0;
            res_l_q       <= '0;
            out_l_q       <= '0;
            out_r_q       <= '0;
            eng_sample_q  <= '0;
            eng_req_q     <= 1'b0;
            out_valid_q   <= 1'b0;
            err_overrun_q <= 1'b0;
            err_timeout_q <= 1'b0;
            lut_addr_q    <= '0;
            lut_wdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            lat_r_q       <= lat_r_d;
            res_l_q       <= res_l_d;
            out_l_q       <= out_l_d;
            out_r_q       <= out_r_d;
            eng_sample_q  <= eng_sample_d;
            eng_req_q     <= eng_req_d;
            out_valid_q   <= out_valid_d;
            err_overrun_q <= err_overrun_d;
            err_timeout_q <= err_timeout_d;
            lut_addr_q    <= lut_addr_d;
            lut_wdata_q   <= lut_wdata_d;
        end
    end

    // The write port shows the buffered entry during the issue cycle, then holds it.
    assign lut_we      = pop;
    assign lut_addr    = pop ? buf_addr : lut_addr_q;
    assign lut_wdata   = pop ? buf_data : lut_wdata_q;
    assign eng_req     = eng_req_q;
    assign eng_sample  = eng_sample_q;
    assign out_l       = out_l_q;
    assign out_r       = out_r_q;
    assign out_valid   = out_valid_q;
    assign err_overrun = err_overrun_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_distortion_sched.sv
// Bench for distortion_sched: frame-schedule reference model, per-cycle output checks,
// directed scenarios with literal expectations, then randomized traffic.
module tb_distortion_sched;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sample_strobe = 1'b0;
    logic [15:0] in_l = '0;
    logic [15:0] in_r = '0;
    logic        bypass = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [9:0]  cfg_addr = '0;
    logic [15:0] cfg_data = '0;
    logic        clr_status = 1'b0;
    logic        eng_req;
    logic [15:0] eng_sample;
    logic        eng_ack = 1'b0;
    logic [15:0] eng_result = '0;
    logic        lut_we;
    logic [9:0]  lut_addr;
    logic [15:0] lut_wdata;
    logic [15:0] out_l, out_r;
    logic        out_valid, err_overrun, err_timeout;

    always #5 clk = ~clk;

    distortion_sched #(
        .DW          (16),
        .LUT_AW      (10),
        .ACK_TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .sample_strobe (sample_strobe),
        .in_l          (in_l),
        .in_r          (in_r),
        .bypass        (bypass),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_addr      (cfg_addr),
        .cfg_data      (cfg_data),
        .clr_status    (clr_status),
        .eng_req       (eng_req),
        .eng_sample    (eng_sample),
        .eng_ack       (eng_ack),
        .eng_result    (eng_result),
        .lut_we        (lut_we),
        .lut_addr      (lut_addr),
        .lut_wdata     (lut_wdata),
        .out_l         (out_l),
        .out_r         (out_r),
        .out_valid     (out_valid),
        .err_overrun   (err_overrun),
        .err_timeout   (err_timeout)
    );

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;

    // stimulus for the next cycle
    bit          n_rst, n_strobe, n_bypass, n_cfgv, n_clr, n_stray;
    logic [15:0] n_inl, n_inr, n_rl, n_rr, n_cd;
    logic [9:0]  n_ca;
    int          n_dl, n_dr;
    int          a_dl, a_dr;
    logic [15:0] a_rl, a_rr;

    // reference model: absolute cycle numbers of the current frame's events
    int          m_done, m_reql, m_reqr, m_wl, m_wr, m_ackl, m_ackr, m_latel, m_later;
    bit          m_tol, m_tor, m_full;
    logic [15:0] m_inl, m_inr, m_rl, m_rr, m_fl, m_fr;
    logic [15:0] e_out_l, e_out_r, e_samp, m_buf_d, m_held_d;
    logic [9:0]  m_buf_a, m_held_a;
    bit          e_ovr, e_to;

    // observations used by the literal checks
    int          obs_vcyc = -1, obs_vcnt = 0, obs_wcyc = -1, obs_reqs = 0;
    logic [9:0]  obs_wa;
    logic [15:0] obs_wd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int min_to(input int d);
        return (d > TO) ? TO : d;
    endfunction

    task automatic model_reset();
        m_done = -100; m_reql = -1; m_reqr = -1; m_wl = -1; m_wr = -1;
        m_ackl = -1; m_ackr = -1; m_latel = -1; m_later = -1;
        m_tol = 0; m_tor = 0; m_full = 0;
        e_out_l = '0; e_out_r = '0; e_samp = '0; e_ovr = 0; e_to = 0;
        m_buf_a = '0; m_buf_d = '0; m_held_a = '0; m_held_d = '0;
    endtask

    task automatic plan_frame(input int k);
        m_inl = in_l; m_inr = in_r; m_rl = a_rl; m_rr = a_rr;
        m_reql = -1; m_reqr = -1; m_wl = -1; m_wr = -1;
        m_ackl = -1; m_ackr = -1; m_latel = -1; m_later = -1;
        m_tol = 0; m_tor = 0;
        if (bypass) begin
            m_done = k + 1; m_fl = in_l; m_fr = in_r;
        end else begin
            m_reql = k + 1;
            m_wl   = m_reql + min_to(a_dl);
            m_tol  = a_dl > TO;
            if (!m_tol) m_ackl = m_reql + a_dl;
            if (a_dl == TO + 1) m_latel = m_reql + TO + 1;
            m_fl   = m_tol ? 16'h0 : a_rl;
            m_reqr = m_wl + 1;
            m_wr   = m_reqr + min_to(a_dr);
            m_tor  = a_dr > TO;
            if (!m_tor) m_ackr = m_reqr + a_dr;
            if (a_dr == TO + 1) m_later = m_reqr + TO + 1;
            m_fr   = m_tor ? 16'h0 : a_rr;
            m_done = m_wr + 1;
        end
    endtask

    // Advance the model across the clock edge that ends cycle k.
    task automatic model_update();
        int k;
        bit idle, pop, set_ov, set_to;
        k = cyc;
        if (reset_n) begin
            idle   = k > m_done;
            pop    = m_full && idle && !sample_strobe;
            set_ov = sample_strobe && !idle;
            set_to = (k == m_wl && m_tol) || (k == m_wr && m_tor);
            e_ovr  = set_ov || (e_ovr && !clr_status);
            e_to   = set_to || (e_to && !clr_status);
            if (pop) begin
                m_held_a = m_buf_a; m_held_d = m_buf_d; m_full = 0;
            end else if (cfg_valid && !m_full) begin
                m_full = 1; m_buf_a = cfg_addr; m_buf_d = cfg_data;
            end
            if (sample_strobe && idle) plan_frame(k);
            if (k + 1 == m_reql) e_samp = m_inl;
            if (k + 1 == m_reqr) e_samp = m_inr;
            if (k + 1 == m_done) begin
                e_out_l = m_fl; e_out_r = m_fr;
            end
        end
    endtask

    task automatic apply();
        reset_n = n_rst;
        if (!n_rst) model_reset();
        sample_strobe = n_strobe; bypass = n_bypass; in_l = n_inl; in_r = n_inr;
        cfg_valid = n_cfgv; cfg_addr = n_ca; cfg_data = n_cd; clr_status = n_clr;
        if (n_strobe) begin
            a_dl = n_dl; a_dr = n_dr; a_rl = n_rl; a_rr = n_rr;
        end
        eng_ack = 1'b0;
        eng_result = 16'($urandom);
        if (n_rst) begin
            if (cyc == m_ackl) begin
                eng_ack = 1'b1; eng_result = m_rl;
            end else if (cyc == m_ackr) begin
                eng_ack = 1'b1; eng_result = m_rr;
            end else if (cyc == m_latel || cyc == m_later) begin
                eng_ack = 1'b1;
            end else if (cyc > m_done && n_stray) begin
                eng_ack = 1'b1;
            end
        end
    endtask

    task automatic compare();
        bit we;
        we = m_full && (cyc > m_done) && !sample_strobe;
        chk("out_valid", out_valid, cyc == m_done);
        chk("out_l", out_l, e_out_l);
        chk("out_r", out_r, e_out_r);
        chk("eng_req", eng_req, (cyc == m_reql) || (cyc == m_reqr));
        chk("eng_sample", eng_sample, e_samp);
        chk("lut_we", lut_we, we);
        chk("lut_addr", lut_addr, we ? m_buf_a : m_held_a);
        chk("lut_wdata", lut_wdata, we ? m_buf_d : m_held_d);
        chk("cfg_ready", cfg_ready, !m_full);
        chk("err_overrun", err_overrun, e_ovr);
        chk("err_timeout", err_timeout, e_to);
        if (out_valid === 1'b1) begin
            obs_vcyc = cyc; obs_vcnt++;
        end
        if (lut_we === 1'b1) begin
            obs_wcyc = cyc; obs_wa = lut_addr; obs_wd = lut_wdata;
        end
        if (eng_req === 1'b1) obs_reqs++;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
        apply();
        @(negedge clk);
        compare();
    endtask

    task automatic quiet();
        n_strobe = 0; n_bypass = 0; n_cfgv = 0; n_clr = 0; n_stray = 0;
    endtask

    task automatic frame(input logic [15:0] l, input logic [15:0] r, input bit byp,
                         input int dl, input int dr, input logic [15:0] rl,
                         input logic [15:0] rr, output int t);
        n_strobe = 1; n_bypass = byp; n_inl = l; n_inr = r;
        n_dl = dl; n_dr = dr; n_rl = rl; n_rr = rr;
        step();
        t = cyc;
        n_strobe = 0; n_bypass = 0; n_cfgv = 0;
    endtask

    function automatic int pick_delay();
        case ($urandom_range(0, 9))
            6:       return 15;
            7:       return 16;
            8:       return 14;
            9:       return 20;
            default: return int'($urandom_range(1, 4));
        endcase
    endfunction

    initial begin
        int t, vc, wc;
        model_reset();
        quiet();
        n_rst = 0; n_inl = '0; n_inr = '0; n_ca = '0; n_cd = '0;
        n_dl = 1; n_dr = 1; n_rl = '0; n_rr = '0;
        repeat (3) step();
        n_rst = 1;
        step();
        chk("reset_cfg_ready", cfg_ready, 1);
        chk("reset_out_l", out_l, 16'h0);

        // engine path, one-cycle acks
        obs_reqs = 0;
        frame(16'h0100, 16'hFF00, 0, 1, 1, 16'h1000, 16'h2000, t);
        repeat (7) step();
        chk("eng_valid_cycle", obs_vcyc, t + 5);
        chk("eng_out_l", out_l, 16'h1000);
        chk("eng_out_r", out_r, 16'h2000);
        chk("eng_req_count", obs_reqs, 2);

        // bypass
        obs_reqs = 0;
        frame(16'h1234, 16'h00FF, 1, 1, 1, 16'h0, 16'h0, t);
        repeat (4) step();
        chk("byp_valid_cycle", obs_vcyc, t + 1);
        chk("byp_out_l", out_l, 16'h1234);
        chk("byp_out_r", out_r, 16'h00FF);
        chk("byp_no_req", obs_reqs, 0);

        // left channel timeout
        frame(16'h0500, 16'h0600, 0, 20, 1, 16'h7777, 16'h0042, t);
        repeat (22) step();
        chk("to_valid_cycle", obs_vcyc, t + 19);
        chk("to_out_l", out_l, 16'h0);
        chk("to_out_r", out_r, 16'h0042);
        chk("to_flag_set", err_timeout, 1);
        n_clr = 1; step(); n_clr = 0; step();
        chk("to_flag_clr", err_timeout, 0);

        // overrun strobe two cycles into a frame
        vc = obs_vcnt;
        frame(16'h0111, 16'h0222, 0, 1, 1, 16'h0AAA, 16'h0BBB, t);
        step();
        n_strobe = 1; n_inl = 16'h7777; n_inr = 16'h6666; n_rl = 16'h5555; n_rr = 16'h4444;
        step();
        n_strobe = 0;
        repeat (6) step();
        chk("ovr_valid_cycle", obs_vcyc, t + 5);
        chk("ovr_one_valid", obs_vcnt, vc + 1);
        chk("ovr_out_l", out_l, 16'h0AAA);
        chk("ovr_out_r", out_r, 16'h0BBB);
        chk("ovr_flag_set", err_overrun, 1);
        n_clr = 1; step(); n_clr = 0; step();
        chk("ovr_flag_clr", err_overrun, 0);

        // cfg write arriving with a strobe waits for the frame
        n_cfgv = 1; n_ca = 10'h3FF; n_cd = 16'hBEEF;
        frame(16'h0010, 16'h0020, 0, 1, 1, 16'h0030, 16'h0040, t);
        repeat (8) step();
        chk("cfg_we_cycle", obs_wcyc, t + 6);
        chk("cfg_we_addr", obs_wa, 10'h3FF);
        chk("cfg_we_data", obs_wd, 16'hBEEF);
        chk("cfg_addr_hold", lut_addr, 10'h3FF);

        // reset during WAIT_R drops the frame and the buffered write
        frame(16'h0300, 16'h0400, 0, 1, 20, 16'h0555, 16'h0, t);
        n_cfgv = 1; n_ca = 10'h055; n_cd = 16'h1234;
        step();
        n_cfgv = 0;
        repeat (5) step();
        vc = obs_vcnt; wc = obs_wcyc;
        n_rst = 0; step(); step(); n_rst = 1;
        repeat (25) step();
        chk("rst_no_valid", obs_vcnt, vc);
        chk("rst_no_lut_we", obs_wcyc, wc);
        chk("rst_cfg_ready", cfg_ready, 1);
        frame(16'h0101, 16'h0202, 0, 2, 3, 16'h0303, 16'h0404, t);
        repeat (12) step();
        chk("post_rst_valid_cycle", obs_vcyc, t + 8);
        chk("post_rst_out_l", out_l, 16'h0303);
        chk("post_rst_out_r", out_r, 16'h0404);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            n_rst    = ($urandom_range(0, 499) != 0);
            n_strobe = ($urandom_range(0, 5) == 0);
            n_bypass = ($urandom_range(0, 3) == 0);
            n_inl    = 16'($urandom);
            n_inr    = 16'($urandom);
            n_dl     = pick_delay();
            n_dr     = pick_delay();
            n_rl     = 16'($urandom);
            n_rr     = 16'($urandom);
            n_cfgv   = ($urandom_range(0, 2) == 0);
            n_ca     = 10'($urandom);
            n_cd     = 16'($urandom);
            n_clr    = ($urandom_range(0, 15) == 0);
            n_stray  = ($urandom_range(0, 3) == 0);
            step();
        end
        n_rst = 1;
        quiet();
        repeat (40) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
